ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  Multi-master arbiter + bus mux in front of the AHB slave (AHB_slave / AHB_APB_slave).
//  Takes N master request/address-phase bundles and grants one owner round-robin.
//  Muxes the owner's address/control onto the shared bus and the data-phase owner's wdata/wstrb.
//  Re-arbitrates only at legal AHB boundaries; a hold limit bounds starvation.
// PARAMETERS
//  N_MASTERS  2   number of masters (2..4); master index width MW = $clog2(N_MASTERS)
//  MAX_HOLD   8   max accepted beats per tenure before a forced handover is allowed (>=1)
// PORTS
//  h_clk      in   1        bus clock
//  h_resetn   in   1        async active-low reset
//  m_busreq   in   N        per-master bus request
//  m_addr     in   N*32     per-master HADDR, master i at [32*i +: 32]
//  m_burst    in   N*3      per-master HBURST
//  m_size     in   N*3      per-master HSIZE
//  m_trans    in   N*2      per-master HTRANS (00 idle, 01 busy, 10 nonseq, 11 seq)
//  m_write    in   N        per-master HWRITE
//  m_wdata    in   N*32     per-master HWDATA (data phase)
//  m_wstrb    in   N*4      per-master HWSTRB (data phase)
//  m_grant    out  N        one-hot grant = address-phase owner
//  m_downer   out  MW       index of current data-phase owner
//  h_addr     out  32       to slave, from addr owner
//  h_burst    out  3        to slave, from addr owner
//  h_size     out  3        to slave, from addr owner
//  h_trans    out  2        to slave; forced 00 when owner's m_busreq=0
//  h_write    out  1        to slave, from addr owner
//  h_wdata    out  32       to slave, from data owner
//  h_wstrb    out  4        to slave, from data owner
//  h_ready    in   1        from slave; also broadcast to masters by the parent
//  h_resp     in   1        from slave; broadcast, meaningful to m_downer only
// BEHAVIOUR
//  Reset: owner=0, downer=0, hold_cnt=0, rr_ptr=1; so m_grant=1 (parked on 0), h_trans=00.
//  Reset is honoured mid-burst: state clears asynchronously, with no completion.
//  Beat accepted = h_ready=1 and h_trans in {10,11} at the clock edge.
//  On every h_ready=1 edge, downer <= owner. When h_ready=0, downer and owner both hold.
//  hold_cnt: 0 on owner change; +1 per accepted beat; saturates at MAX_HOLD.
//  Re-arbitrate at an edge with h_ready=1 when any of these holds:
//   (a) owner m_busreq=0;
//   (b) owner m_trans=00;
//   (c) hold_cnt>=MAX_HOLD and owner m_trans=10 (never inside seq/busy).
//   Never re-arbitrate while owner m_trans is 01 or 11.
//  Round-robin pick: first requester scanning rr_ptr, rr_ptr+1, ... mod N.
//   If the pick differs from owner: owner <= pick, rr_ptr <= pick+1, hold_cnt <= 0.
//   With no requester: owner holds (parks), h_trans forced 00.
//   Only the current owner requesting: it keeps the bus; hold_cnt keeps saturated.
//  Grant latency: new owner's address phase drives the bus the cycle after the edge.
//   m_grant is combinational from the owner register; the master samples grant with h_ready.
//  Handover during a wait state: arbitration is deferred until h_ready=1.
//   The old owner's data phase completes with its wdata (downer).
//  Pipelining: one address phase and one data phase in flight.
//   At a handover edge, downer = old owner and owner = new owner.
//  h_resp=1 (error): the arbiter takes no action; the master must respond with idle, which triggers (b).
//  Outputs: all h_* muxes purely combinational.
//   Only owner, downer, hold_cnt and rr_ptr are registers.
// TESTING
//  1. Reset, m0 busreq, write nonseq addr 0x4, size 010, wdata 0xA5A5A5A5
//     -> m_grant=01, h_addr=0x4; next cycle h_wdata=0xA5A5A5A5, m_downer=0.
//  2. m0, m1 request same cycle, each issues single nonseq then idle
//     -> grant sequence 01, 10, 01; m_downer lags m_grant by one ready cycle.
//  3. m1 runs INCR4 (burst 011, nonseq+3 seq) while m0 requests
//     -> no grant change until m1 drives idle; m0 owns the cycle after.
//  4. MAX_HOLD=4; m0 issues back-to-back nonseq singles, m1 requests
//     -> grant moves to m1 after the 4th accepted beat.
//  5. Slave holds h_ready=0 for 3 cycles on m0's last data phase while m1 requests
//     -> owner/downer frozen; h_wdata stays m0's; m1 granted at the edge h_ready=1.
//  6. Assert h_resetn=0 mid m1 INCR4
//     -> same cycle m_grant=01, h_trans=00, m_downer=0; hold_cnt=0 after release.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB multi-master arbiter with address/data phase bus muxing.
// Ownership changes only at h_ready edges outside SEQ/BUSY; a hold limit bounds a master's tenure.
module ahb_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int MAX_HOLD  = 8
) (
  input  logic                           h_clk,
  input  logic                           h_resetn,
  input  logic [N_MASTERS-1:0]           m_busreq,
  input  logic [N_MASTERS*32-1:0]        m_addr,
  input  logic [N_MASTERS*3-1:0]         m_burst,
  input  logic [N_MASTERS*3-1:0]         m_size,
  input  logic [N_MASTERS*2-1:0]         m_trans,
  input  logic [N_MASTERS-1:0]           m_write,
  input  logic [N_MASTERS*32-1:0]        m_wdata,
  input  logic [N_MASTERS*4-1:0]         m_wstrb,
  output logic [N_MASTERS-1:0]           m_grant,
  output logic [$clog2(N_MASTERS)-1:0]   m_downer,
  output logic [31:0]                    h_addr,
  output logic [2:0]                     h_burst,
  output logic [2:0]                     h_size,
  output logic [1:0]                     h_trans,
  output logic                           h_write,
  output logic [31:0]                    h_wdata,
  output logic [3:0]                     h_wstrb,
  input  logic                           h_ready,
  input  logic                           h_resp
);

  localparam int MW = $clog2(N_MASTERS);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [MW-1:0] owner_r;
  logic [MW-1:0] downer_r;
  logic [HW-1:0] hold_cnt_r;
  logic [MW-1:0] rr_ptr_r;

  logic [MW-1:0] owner_nx_s;
  logic [MW-1:0] downer_nx_s;
  logic [HW-1:0] hold_cnt_nx_s;
  logic [MW-1:0] rr_ptr_nx_s;

  logic [31:0] addr_a  [N_MASTERS];
  logic [2:0]  burst_a [N_MASTERS];
  logic [2:0]  size_a  [N_MASTERS];
  logic [1:0]  trans_a [N_MASTERS];
  logic [31:0] wdata_a [N_MASTERS];
  logic [3:0]  wstrb_a [N_MASTERS];

  logic [MW-1:0] pick_s;
  logic [MW-1:0] cand_s;
  logic          found_s;
  logic          own_req_s;
  logic [1:0]    own_trans_s;
  logic          in_burst_s;
  logic          hold_hit_s;
  logic          rearb_s;
  logic          change_s;
  logic          accept_s;

  // The error response needs no arbiter action; the master's idle triggers re-arbitration.
  logic unused_s;
  assign unused_s = h_resp;

  // Per-master unpacking of the flat input buses, plus one-hot grant decode
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = m_addr[32*i +: 32];
    assign burst_a[i] = m_burst[3*i +: 3];
    assign size_a[i]  = m_size[3*i +: 3];
    assign trans_a[i] = m_trans[2*i +: 2];
    assign wdata_a[i] = m_wdata[32*i +: 32];
    assign wstrb_a[i] = m_wstrb[4*i +: 4];
    assign m_grant[i] = (owner_r == MW'(i));
  end

  assign own_req_s   = m_busreq[owner_r];
  assign own_trans_s = trans_a[owner_r];

  assign h_addr   = addr_a[owner_r];
  assign h_burst  = burst_a[owner_r];
  assign h_size   = size_a[owner_r];
  assign h_write  = m_write[owner_r];
  assign h_wdata  = wdata_a[downer_r];
  assign h_wstrb  = wstrb_a[downer_r];
  assign m_downer = downer_r;

  // Shared HTRANS: idle while in reset or when the owner has dropped its request
  always_comb begin
    h_trans = 2'b00;
    if (!h_resetn) begin
      h_trans = 2'b00;
    end else if (own_req_s) begin
      h_trans = own_trans_s;
    end else begin
      h_trans = 2'b00;
    end
  end

  // Round-robin search: first requester starting at rr_ptr
  always_comb begin
    pick_s  = owner_r;
    found_s = 1'b0;
    cand_s  = rr_ptr_r;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand_s  = MW'((int'(rr_ptr_r) + k) % N_MASTERS);
      pick_s  = (!found_s && m_busreq[cand_s]) ? cand_s : pick_s;
      found_s = found_s | m_busreq[cand_s];
    end
  end

  // Handover is only legal outside SEQ/BUSY, and a forced handover only at a NONSEQ
  assign in_burst_s = (own_trans_s == 2'b01) || (own_trans_s == 2'b11);
  assign hold_hit_s = (hold_cnt_r >= HW'(MAX_HOLD)) && (own_trans_s == 2'b10);
  assign rearb_s    = h_ready && !in_burst_s &&
                      (!own_req_s || (own_trans_s == 2'b00) || hold_hit_s);
  assign change_s   = rearb_s && found_s && (pick_s != owner_r);
  assign accept_s   = h_ready && h_trans[1];

  // Next-state for owner, data-phase owner, tenure counter and round-robin pointer
  always_comb begin
    owner_nx_s    = owner_r;
    downer_nx_s   = downer_r;
    hold_cnt_nx_s = hold_cnt_r;
    rr_ptr_nx_s   = rr_ptr_r;
    if (h_ready) begin
      downer_nx_s = owner_r;
    end else begin
      downer_nx_s = downer_r;
    end
    if (change_s) begin
      owner_nx_s    = pick_s;
      rr_ptr_nx_s   = MW'((int'(pick_s) + 1) % N_MASTERS);
      hold_cnt_nx_s = {HW{1'b0}};
    end else if (accept_s && (hold_cnt_r < HW'(MAX_HOLD))) begin
      hold_cnt_nx_s = hold_cnt_r + HW'(1);
    end else begin
      hold_cnt_nx_s = hold_cnt_r;
    end
  end

  // Arbitration state registers; reset parks the bus on master 0
  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) begin
      owner_r    <= {MW{1'b0}};
      downer_r   <= {MW{1'b0}};
      hold_cnt_r <= {HW{1'b0}};
      rr_ptr_r   <= MW'(1 % N_MASTERS);
    end else begin
      owner_r    <= owner_nx_s;
      downer_r   <= downer_nx_s;
      hold_cnt_r <= hold_cnt_nx_s;
      rr_ptr_r   <= rr_ptr_nx_s;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (2 masters, hold limit 4): vector table plus
// hand-written reset-mid-burst sequence.
module tb_ahb_bus_arbiter;

  logic        h_clk = 1'b0;
  logic        h_resetn;
  logic [1:0]  m_busreq;
  logic [63:0] m_addr;
  logic [5:0]  m_burst;
  logic [5:0]  m_size;
  logic [3:0]  m_trans;
  logic [1:0]  m_write;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_grant;
  logic        m_downer;
  logic [31:0] h_addr;
  logic [2:0]  h_burst;
  logic [2:0]  h_size;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [31:0] h_wdata;
  logic [3:0]  h_wstrb;
  logic        h_ready;
  logic        h_resp;

  int checks   = 0;
  int failures = 0;

  always #5 h_clk = ~h_clk;

  ahb_bus_arbiter #(.N_MASTERS(2), .MAX_HOLD(4)) dut (
    .h_clk(h_clk), .h_resetn(h_resetn),
    .m_busreq(m_busreq), .m_addr(m_addr), .m_burst(m_burst), .m_size(m_size),
    .m_trans(m_trans), .m_write(m_write), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_grant(m_grant), .m_downer(m_downer),
    .h_addr(h_addr), .h_burst(h_burst), .h_size(h_size), .h_trans(h_trans),
    .h_write(h_write), .h_wdata(h_wdata), .h_wstrb(h_wstrb),
    .h_ready(h_ready), .h_resp(h_resp)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        rdy;
    logic [1:0]  e_grant;
    logic        e_downer;
    logic [31:0] e_addr;
    logic [1:0]  e_trans;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] t0, input logic [31:0] a0,
                              input logic [1:0] t1, input logic [31:0] a1, input logic rdy,
                              input logic [1:0] eg, input logic ed, input logic [31:0] ea,
                              input logic [1:0] et);
    vec_t v;
    v.req = req; v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1; v.rdy = rdy;
    v.e_grant = eg; v.e_downer = ed; v.e_addr = ea; v.e_trans = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] t0, input logic [31:0] a0,
                       input logic [1:0] t1, input logic [31:0] a1, input logic rdy);
    m_busreq = req;
    m_trans  = {t1, t0};
    m_addr   = {a1, a0};
    h_ready  = rdy;
  endtask

  initial begin
    // master 0: write, word, single; master 1: read, byte, INCR4
    m_burst  = {3'b011, 3'b000};
    m_size   = {3'b000, 3'b010};
    m_write  = 2'b01;
    m_wdata  = {32'h3C3C_0001, 32'hA5A5_A5A5};
    m_wstrb  = {4'h3, 4'hF};
    h_resp   = 1'b0;
    h_resetn = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 2'b00, 32'h0, 1'b1);

    // test 1: single write from m0
    vecs[0]  = mk(2'b01, 2'b10, 32'h4,   2'b00, 32'h0,   1'b1, 2'b01, 1'b0, 32'h4,   2'b10);
    vecs[1]  = mk(2'b00, 2'b00, 32'h0,   2'b00, 32'h0,   1'b1, 2'b01, 1'b0, 32'h0,   2'b00);
    // test 2: both request, singles then idle
    vecs[2]  = mk(2'b11, 2'b10, 32'h100, 2'b10, 32'h200, 1'b1, 2'b01, 1'b0, 32'h100, 2'b10);
    vecs[3]  = mk(2'b11, 2'b00, 32'h0,   2'b10, 32'h200, 1'b1, 2'b01, 1'b0, 32'h0,   2'b00);
    vecs[4]  = mk(2'b11, 2'b00, 32'h0,   2'b10, 32'h200, 1'b1, 2'b10, 1'b0, 32'h200, 2'b10);
    vecs[5]  = mk(2'b11, 2'b00, 32'h0,   2'b00, 32'h0,   1'b1, 2'b10, 1'b1, 32'h0,   2'b00);
    vecs[6]  = mk(2'b01, 2'b00, 32'h0,   2'b00, 32'h0,   1'b1, 2'b01, 1'b1, 32'h0,   2'b00);
    // test 3: m1 INCR4 while m0 waits
    vecs[7]  = mk(2'b11, 2'b00, 32'h0,   2'b10, 32'h300, 1'b1, 2'b01, 1'b0, 32'h0,   2'b00);
    vecs[8]  = mk(2'b11, 2'b10, 32'h400, 2'b10, 32'h300, 1'b1, 2'b10, 1'b0, 32'h300, 2'b10);
    vecs[9]  = mk(2'b11, 2'b10, 32'h400, 2'b11, 32'h304, 1'b1, 2'b10, 1'b1, 32'h304, 2'b11);
    vecs[10] = mk(2'b11, 2'b10, 32'h400, 2'b11, 32'h308, 1'b1, 2'b10, 1'b1, 32'h308, 2'b11);
    vecs[11] = mk(2'b11, 2'b10, 32'h400, 2'b11, 32'h30C, 1'b1, 2'b10, 1'b1, 32'h30C, 2'b11);
    vecs[12] = mk(2'b11, 2'b10, 32'h400, 2'b00, 32'h0,   1'b1, 2'b10, 1'b1, 32'h0,   2'b00);
    vecs[13] = mk(2'b01, 2'b10, 32'h400, 2'b00, 32'h0,   1'b1, 2'b01, 1'b1, 32'h400, 2'b10);
    // test 5: three wait states on m0's last data phase, m1 requesting
    vecs[14] = mk(2'b11, 2'b00, 32'h0,   2'b10, 32'h500, 1'b0, 2'b01, 1'b0, 32'h0,   2'b00);
    vecs[15] = mk(2'b11, 2'b00, 32'h0,   2'b10, 32'h500, 1'b0, 2'b01, 1'b0, 32'h0,   2'b00);
    vecs[16] = mk(2'b11, 2'b00, 32'h0,   2'b10, 32'h500, 1'b0, 2'b01, 1'b0, 32'h0,   2'b00);
    vecs[17] = mk(2'b11, 2'b00, 32'h0,   2'b10, 32'h500, 1'b1, 2'b01, 1'b0, 32'h0,   2'b00);
    vecs[18] = mk(2'b11, 2'b00, 32'h0,   2'b10, 32'h500, 1'b1, 2'b10, 1'b0, 32'h500, 2'b10);
    // m1 drops request while still driving NONSEQ: HTRANS forced idle
    vecs[19] = mk(2'b01, 2'b10, 32'h600, 2'b10, 32'h0,   1'b1, 2'b10, 1'b1, 32'h0,   2'b00);
    // test 4: hold limit 4 with back-to-back NONSEQ from m0
    vecs[20] = mk(2'b01, 2'b10, 32'h600, 2'b00, 32'h0,   1'b1, 2'b01, 1'b1, 32'h600, 2'b10);
    vecs[21] = mk(2'b11, 2'b10, 32'h604, 2'b10, 32'h700, 1'b1, 2'b01, 1'b0, 32'h604, 2'b10);
    vecs[22] = mk(2'b11, 2'b10, 32'h608, 2'b10, 32'h700, 1'b1, 2'b01, 1'b0, 32'h608, 2'b10);
    vecs[23] = mk(2'b11, 2'b10, 32'h60C, 2'b10, 32'h700, 1'b1, 2'b01, 1'b0, 32'h60C, 2'b10);
    vecs[24] = mk(2'b11, 2'b10, 32'h610, 2'b10, 32'h700, 1'b1, 2'b01, 1'b0, 32'h610, 2'b10);
    vecs[25] = mk(2'b11, 2'b10, 32'h614, 2'b10, 32'h700, 1'b1, 2'b10, 1'b0, 32'h700, 2'b10);

    @(negedge h_clk);
    #1;
    chk("reset grant", 32'(m_grant), 32'h1);
    chk("reset trans", 32'(h_trans), 32'h0);
    chk("reset downer", 32'(m_downer), 32'h0);
    h_resetn = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge h_clk);
      drive(vecs[i].req, vecs[i].t0, vecs[i].a0, vecs[i].t1, vecs[i].a1, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d grant", i),  32'(m_grant),  32'(vecs[i].e_grant));
      chk($sformatf("v%0d downer", i), 32'(m_downer), 32'(vecs[i].e_downer));
      chk($sformatf("v%0d trans", i),  32'(h_trans),  32'(vecs[i].e_trans));
      chk($sformatf("v%0d addr", i),   h_addr,        vecs[i].e_addr);
      chk($sformatf("v%0d size", i),   32'(h_size),   (vecs[i].e_grant == 2'b01) ? 32'h2 : 32'h0);
      chk($sformatf("v%0d burst", i),  32'(h_burst),  (vecs[i].e_grant == 2'b01) ? 32'h0 : 32'h3);
      chk($sformatf("v%0d write", i),  32'(h_write),  (vecs[i].e_grant == 2'b01) ? 32'h1 : 32'h0);
      chk($sformatf("v%0d wdata", i),  h_wdata,  vecs[i].e_downer ? 32'h3C3C_0001 : 32'hA5A5_A5A5);
      chk($sformatf("v%0d wstrb", i),  32'(h_wstrb),  vecs[i].e_downer ? 32'h3 : 32'hF);
    end

    // test 6: m1 mid INCR4 (two SEQ beats), then asynchronous reset
    @(negedge h_clk);
    drive(2'b11, 2'b00, 32'h0, 2'b11, 32'h704, 1'b1);
    @(negedge h_clk);
    drive(2'b11, 2'b00, 32'h0, 2'b11, 32'h708, 1'b1);
    #1;
    chk("pre-reset grant", 32'(m_grant), 32'h2);
    chk("pre-reset downer", 32'(m_downer), 32'h1);
    @(negedge h_clk);
    h_resetn = 1'b0;
    drive(2'b11, 2'b10, 32'h800, 2'b11, 32'h70C, 1'b1);
    #1;
    chk("mid-reset grant", 32'(m_grant), 32'h1);
    chk("mid-reset trans", 32'(h_trans), 32'h0);
    chk("mid-reset downer", 32'(m_downer), 32'h0);

    // hold count restarts at 0: m0 keeps the bus through 4 accepted beats plus the 5th NONSEQ
    @(negedge h_clk);
    h_resetn = 1'b1;
    drive(2'b11, 2'b10, 32'h800, 2'b10, 32'h700, 1'b1);
    #1;
    chk("post-reset addr", h_addr, 32'h800);
    chk("post-reset trans", 32'(h_trans), 32'h2);
    for (int b = 0; b < 5; b++) begin
      if (b > 0) begin
        @(negedge h_clk);
        drive(2'b11, 2'b10, 32'h800 + 32'(4 * b), 2'b10, 32'h700, 1'b1);
        #1;
      end
      chk($sformatf("post-reset hold beat%0d grant", b), 32'(m_grant), 32'h1);
    end
    @(negedge h_clk);
    drive(2'b11, 2'b10, 32'h814, 2'b10, 32'h700, 1'b1);
    #1;
    chk("post-reset handover grant", 32'(m_grant), 32'h2);
    chk("post-reset handover addr", h_addr, 32'h700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
